// File: rtl/types_pkg.sv
// Shared types and sizing constants for the reservation-station scheduler.
package types_pkg;

    localparam int RS_DEPTH  = 8;
    localparam int RS_TAG_W  = 7;
    localparam int ROB_IDX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_index;
        logic [RS_TAG_W-1:0]  pd;
        logic [7:0]           op;
        logic [RS_TAG_W-1:0]  ps1;
        logic                 ps1_ready;
        logic [RS_TAG_W-1:0]  ps2;
        logic                 ps2_ready;
    } rs_data;

endpackage

// File: rtl/rs_select.sv
// Issue picker: lowest ready slot, or oldest by ROB distance from rob_head
// when RS_AGE_SELECT_EN is defined (ties go to the lowest slot).
module rs_select
    import types_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic [DEPTH-1:0]                ready,
    input  logic [DEPTH-1:0][ROB_IDX_W-1:0] rob_idx,
    input  logic [ROB_IDX_W-1:0]            rob_head,
    output logic [DEPTH-1:0]                grant,
    output logic                            valid
);

`ifdef RS_AGE_SELECT_EN
    logic [ROB_IDX_W-1:0] age;
    logic [ROB_IDX_W-1:0] best_age;

    always_comb begin
        grant    = '0;
        valid    = 1'b0;
        best_age = '1;
        age      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = rob_idx[i] - rob_head;
            if (ready[i] && (!valid || age < best_age)) begin
                grant    = '0;
                grant[i] = 1'b1;
                valid    = 1'b1;
                best_age = age;
            end
        end
    end
`else
    logic unused_age;
    assign unused_age = ^{rob_head, rob_idx};

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !valid) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rs_scheduler.sv
// Reservation station: dispatch, CDB wakeup, single issue port, flush.
// Selection policy is chosen in rs_select via RS_AGE_SELECT_EN.
module rs_scheduler
    import types_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   disp_valid,
    input  rs_data                 disp_data,
    output logic                   disp_ready,
    input  logic                   cdb_valid,
    input  logic [RS_TAG_W-1:0]    cdb_pd,
    input  logic [ROB_IDX_W-1:0]   rob_head,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output rs_data                 issue_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    rs_data q [DEPTH];

    logic [DEPTH-1:0]                rdy;
    logic [DEPTH-1:0]                grant;
    logic [DEPTH-1:0][ROB_IDX_W-1:0] rob_vec;
    logic                            sel_valid;
    logic                            hold;
    logic [IW-1:0]                   hold_idx;
    logic [IW-1:0]                   sel_idx;
    logic [IW-1:0]                   free_idx;
    logic                            disp_ok;
    logic                            fire;
    rs_data                          ins;

    always_comb begin
        rdy     = '0;
        rob_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i]     = q[i].valid & q[i].ps1_ready & q[i].ps2_ready;
            rob_vec[i] = q[i].rob_index;
        end
    end

    rs_select #(.DEPTH(DEPTH)) u_sel (
        .ready    (rdy),
        .rob_idx  (rob_vec),
        .rob_head (rob_head),
        .grant    (grant),
        .valid    (sel_valid)
    );

    // A stalled offer stays pinned so issue_data is stable until accepted.
    always_comb begin
        sel_idx = '0;
        if (hold) begin
            sel_idx = hold_idx;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (grant[i]) sel_idx = IW'(i);
        end
    end

    assign issue_valid = (hold | sel_valid) & !flush;
    assign issue_data  = q[sel_idx];
    assign fire        = issue_valid & issue_ready;
    assign disp_ready  = count < CW'(DEPTH);
    assign disp_ok     = disp_valid & disp_ready & !flush;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!q[i].valid) free_idx = IW'(i);
    end

    // Same-cycle CDB bypass and the hardwired-ready tag 0.
    always_comb begin
        ins           = disp_data;
        ins.valid     = 1'b1;
        ins.ps1_ready = disp_data.ps1_ready
                      | (cdb_valid && cdb_pd == disp_data.ps1)
                      | (disp_data.ps1 == '0);
        ins.ps2_ready = disp_data.ps2_ready
                      | (cdb_valid && cdb_pd == disp_data.ps2)
                      | (disp_data.ps2 == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count    <= '0;
            hold     <= 1'b0;
            hold_idx <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
            count <= '0;
            hold  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[i].valid && cdb_valid) begin
                    if (q[i].ps1 == cdb_pd) q[i].ps1_ready <= 1'b1;
                    if (q[i].ps2 == cdb_pd) q[i].ps2_ready <= 1'b1;
                end
            end
            if (fire) q[sel_idx].valid <= 1'b0;
            if (disp_ok) q[free_idx] <= ins;
            hold     <= issue_valid & !issue_ready;
            hold_idx <= sel_idx;
            case ({disp_ok, fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Directed-vector bench for rs_scheduler with hand-computed expectations.
module tb_rs_scheduler;
    import types_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic                 disp_valid;
    rs_data               disp_data;
    logic                 disp_ready;
    logic                 cdb_valid;
    logic [RS_TAG_W-1:0]  cdb_pd;
    logic [ROB_IDX_W-1:0] rob_head;
    logic                 issue_valid;
    logic                 issue_ready;
    rs_data               issue_data;
    logic [3:0]           count;

    int n_chk;
    int n_fail;
    rs_data exp_d;

    rs_scheduler #(.DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_data   (disp_data),
        .disp_ready  (disp_ready),
        .cdb_valid   (cdb_valid),
        .cdb_pd      (cdb_pd),
        .rob_head    (rob_head),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_data  (issue_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rs_data mk(input int ps1, input bit r1,
                                  input int ps2, input bit r2,
                                  input int rob);
        rs_data d;
        d           = '0;
        d.ps1       = 7'(ps1);
        d.ps1_ready = r1;
        d.ps2       = 7'(ps2);
        d.ps2_ready = r2;
        d.rob_index = 4'(rob);
        d.pd        = 7'(rob + 64);
        d.op        = 8'(rob);
        return d;
    endfunction

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_data   = '0;
        cdb_valid   = 1'b0;
        cdb_pd      = '0;
        rob_head    = '0;
        issue_ready = 1'b0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        tick();
        reset = 1'b0;
        tick();

        // wakeup one cycle after broadcast
        disp_valid = 1'b1;
        disp_data  = mk(5, 0, 0, 0, 0);
        tick();
        disp_valid = 1'b0;
        chk("wk_count", count, 1);
        chk("wk_wait", issue_valid, 0);
        cdb_valid = 1'b1;
        cdb_pd    = 7'd5;
        #1;
        chk("wk_not_comb", issue_valid, 0);
        tick();
        cdb_valid = 1'b0;
        chk("wk_valid", issue_valid, 1);
        chk("wk_ps1", issue_data.ps1, 5);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("wk_drain", count, 0);
        chk("wk_idle", issue_valid, 0);

        // same-cycle bypass, then stall for three cycles
        disp_valid = 1'b1;
        disp_data  = mk(9, 0, 0, 0, 1);
        cdb_valid  = 1'b1;
        cdb_pd     = 7'd9;
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        exp_d       = mk(9, 1, 0, 1, 1);
        exp_d.valid = 1'b1;
        chk("byp_valid", issue_valid, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", issue_data, exp_d);
            chk("stall_count", count, 1);
        end
        issue_ready = 1'b1;
        disp_valid  = 1'b1;
        disp_data   = mk(0, 1, 0, 1, 2);
        tick();
        disp_valid = 1'b0;
        chk("disp_issue_cnt", count, 1);
        tick();
        issue_ready = 1'b0;
        chk("drain2", count, 0);

        // stalled offer must not switch when a lower slot wakes
        disp_valid = 1'b1;
        disp_data  = mk(20, 0, 0, 1, 3);
        tick();
        disp_data = mk(0, 1, 0, 1, 2);
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b1;
        cdb_pd     = 7'd20;
        tick();
        cdb_valid = 1'b0;
        chk("pin_keep", issue_data.rob_index, 2);
        issue_ready = 1'b1;
        tick();
        chk("pin_next", issue_data.rob_index, 3);
        tick();
        issue_ready = 1'b0;
        chk("pin_drain", count, 0);

        // selection policy with rob_head = 14
        rob_head   = 4'd14;
        disp_valid = 1'b1;
        disp_data  = mk(30, 0, 0, 1, 15);
        tick();
        disp_data = mk(30, 0, 0, 1, 1);
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b1;
        cdb_pd     = 7'd30;
        tick();
        cdb_valid = 1'b0;
        chk("sel_a_first", issue_data.rob_index, 15);
        issue_ready = 1'b1;
        tick();
        chk("sel_a_second", issue_data.rob_index, 1);
        tick();
        issue_ready = 1'b0;
        disp_valid  = 1'b1;
        disp_data   = mk(31, 0, 0, 1, 1);
        tick();
        disp_data = mk(31, 0, 0, 1, 15);
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b1;
        cdb_pd     = 7'd31;
        tick();
        cdb_valid = 1'b0;
`ifdef RS_AGE_SELECT_EN
        chk("sel_b_first", issue_data.rob_index, 15);
`else
        chk("sel_b_first", issue_data.rob_index, 1);
`endif
        issue_ready = 1'b1;
        tick();
`ifdef RS_AGE_SELECT_EN
        chk("sel_b_second", issue_data.rob_index, 1);
`else
        chk("sel_b_second", issue_data.rob_index, 15);
`endif
        tick();
        issue_ready = 1'b0;
        rob_head    = '0;
        chk("sel_drain", count, 0);

        // fill to capacity, drop the ninth, flush with dispatch
        disp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            disp_data = mk(40, 0, 0, 1, i);
            tick();
        end
        chk("full_count", count, 8);
        chk("full_ready", disp_ready, 0);
        disp_data = mk(0, 1, 0, 1, 9);
        tick();
        chk("drop_count", count, 8);
        chk("drop_issue", issue_valid, 0);
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("flush_full_cnt", count, 0);
        chk("flush_full_rdy", disp_ready, 1);

        // five ready entries, flush with concurrent dispatch
        disp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            disp_data = mk(0, 1, 0, 1, i);
            tick();
        end
        chk("five_count", count, 5);
        chk("five_issue", issue_valid, 1);
        flush = 1'b1;
        #1;
        chk("flush_comb", issue_valid, 0);
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_issue", issue_valid, 0);

        // asynchronous reset mid-run
        disp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            disp_data = mk(0, 1, 0, 1, i);
            tick();
        end
        disp_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", count, 0);
        chk("async_issue", issue_valid, 0);
        chk("async_ready", disp_ready, 1);
        #2;
        reset = 1'b0;
        tick();
        disp_valid = 1'b1;
        disp_data  = mk(0, 1, 0, 1, 4);
        tick();
        disp_valid = 1'b0;
        chk("post_rst_count", count, 1);
        chk("post_rst_issue", issue_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
